fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage; drives the IF/ID pipeline register inputs (instr, PC_inc, stall_n write enable).
//  Owns the PC and issues one request at a time to a multi-cycle instruction memory.
//  Handles hazard stalls, branch redirects (with NOP flush into IF/ID) and HALT.
// PARAMETERS
//  RESET_PC     16'h0000  PC value after reset
//  HALT_OPCODE  5'b00000  instr[15:11] value that stops fetch
//  NOP_INSTR    16'h0800  instruction written into IF/ID on a flush
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  stall_n      in   1   hazard unit; 0 = IF/ID must hold (active low)
//  redirect     in   1   taken branch/jump resolved downstream
//  redirect_pc  in   16  target PC for redirect
//  imem_req     out  1   request valid
//  imem_addr    out  16  request address (= PC)
//  imem_busy    in   1   memory cannot accept a request this cycle
//  imem_done    in   1   response valid (>=1 cycle after accept)
//  imem_rdata   in   16  response instruction
//  out_instr    out  16  to IF/ID in_instr
//  out_PC_inc   out  16  to IF/ID in_PC_inc
//  out_stall_n  out  1   to IF/ID in_stall_n; 1 = IF/ID captures this cycle
//  halted       out  1   fetch stopped on HALT
//  err          out  1   error flag (see CONFIGURATION)
// BEHAVIOUR
//  - States: FETCH, WAIT, HOLD, DRAIN, HALT. Reset -> FETCH, pc=RESET_PC, all outputs 0 except imem_addr=RESET_PC.
//  - imem_req = 1 only in FETCH; imem_addr = pc always. Accept = FETCH & !imem_busy -> WAIT.
//  - WAIT & imem_done & stall_n: out_instr=imem_rdata, out_PC_inc=pc+2, out_stall_n=1 (combinational, same cycle);
//    pc<=pc+2; next FETCH, or HALT if imem_rdata[15:11]==HALT_OPCODE (pc not advanced on HALT).
//  - WAIT & imem_done & !stall_n: latch rdata into hold reg -> HOLD; out_stall_n=0.
//  - HOLD: present hold reg; when stall_n=1 -> out_stall_n=1, pc<=pc+2, go FETCH/HALT as above.
//  - Redirect (any state, highest priority): pc<=redirect_pc; out_instr=NOP_INSTR, out_PC_inc=redirect_pc,
//    out_stall_n=1 regardless of stall_n; hold reg discarded. From WAIT without imem_done -> DRAIN; else -> FETCH.
//  - DRAIN: wait for outstanding imem_done, discard data, -> FETCH. Redirect in DRAIN updates pc, stays DRAIN.
//  - Redirect coincident with imem_done in WAIT: response discarded, -> FETCH.
//  - HALT: halted=1, no requests, out_stall_n=0; leaves only via redirect (older mispredicted branch) or reset.
//  - Latency: first out_stall_n=1 no earlier than 2 cycles after reset release (accept + >=1 memory cycle).
//  - PC arithmetic modulo 2^16: pc 16'hFFFE -> PC_inc 16'h0000.
//  - Reset asserted mid-request: state/pc/hold cleared immediately; a later stray imem_done in FETCH is ignored.
// CONFIGURATION
//  FETCH_ERR_EN defined: err = 1 when any input is X (^inputs===1'bX) or imem_done arrives
//    in FETCH/HOLD/HALT (no request outstanding); registered, sticky until rst.
//  FETCH_ERR_EN undefined: err tied to 1'b0; no checking logic synthesized.
// STRUCTURE
//  Shared package/include: state encodings (FETCH..HALT), opcode field position [15:11], HALT/NOP constants.
//  pc and hold reg built from the existing register module (writeEn-gated); no new sub-module.
// TESTING
//  1 reset, imem latency 1, stall_n=1 -> out_stall_n pulses with PC_inc 0x0002,0x0004,0x0006 on successive responses.
//  2 stall_n=0 during response of instr 0x4A21 -> out_stall_n=0 in HOLD; stall_n=1 3 cycles later -> 0x4A21 presented once.
//  3 redirect to 0x0100 while WAIT, no done -> NOP 0x0800 written, DRAIN discards next response, next request addr 0x0100.
//  4 response 0x0000 (HALT) -> presented once, halted=1, imem_req stays 0 for 10 cycles; redirect 0x0040 -> fetch resumes.
//  5 pc=0xFFFE fetch -> out_PC_inc=0x0000, next imem_addr=0x0000.
//  6 FETCH_ERR_EN: imem_done pulsed in FETCH -> err=1 next cycle and held; without macro err stays 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states,
// opcode field position and the default HALT / NOP constants.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN,
        ST_HALT
    } fetch_state_e;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 11;

    localparam logic [15:0] RESET_PC_DEF    = 16'h0000;
    localparam logic [4:0]  HALT_OPCODE_DEF = 5'b00000;
    localparam logic [15:0] NOP_INSTR_DEF   = 16'h0800;

    function automatic logic is_halt(input logic [15:0] instr, input logic [4:0] halt_opc);
        return instr[OPC_MSB:OPC_LSB] == halt_opc;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Request/response bus between the fetch stage and the multi-cycle
// instruction memory. One request outstanding at a time.
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_busy;
    logic        imem_done;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_busy, imem_done, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_busy, imem_done, imem_rdata
    );
endinterface

// File: rtl/fetch_unit_reg.sv
// Write-enable gated register with asynchronous active-high reset,
// used for the PC and the instruction hold register.
module fetch_unit_reg #(
    parameter int unsigned       WIDTH     = 16,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Capture d_i when enabled; reset to RESET_VAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q_o <= RESET_VAL;
        else if (we_i) q_o <= d_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues one request at a time to
// the instruction memory and feeds the IF/ID register (instr, PC_inc,
// write enable). Handles hazard stalls, branch redirects with NOP flush,
// and HALT.
// Optional feature: define FETCH_ERR_EN to build the sticky error checker;
// without it err is tied low.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [4:0]  HALT_OPCODE = HALT_OPCODE_DEF,
    parameter logic [15:0] NOP_INSTR   = NOP_INSTR_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_n,
    input  logic         redirect,
    input  logic [15:0]  redirect_pc,
    fetch_unit_if.master imem,
    output logic [15:0]  out_instr,
    output logic [15:0]  out_PC_inc,
    output logic         out_stall_n,
    output logic         halted,
    output logic         err
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d, pc_inc, hold_q, cand_instr;
    logic         pc_we, hold_we, req, cand_valid;

    fetch_unit_reg #(.WIDTH(16), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .we_i(pc_we), .d_i(pc_d), .q_o(pc_q)
    );

    fetch_unit_reg #(.WIDTH(16), .RESET_VAL(16'h0000)) u_hold (
        .clk(clk), .rst(rst), .we_i(hold_we), .d_i(imem.imem_rdata), .q_o(hold_q)
    );

    assign pc_inc         = pc_q + 16'd2;
    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = req;

    // An instruction is ready for IF/ID either straight from memory or from the hold register.
    assign cand_valid = (state_q == ST_HOLD) || (state_q == ST_WAIT && imem.imem_done);
    assign cand_instr = (state_q == ST_HOLD) ? hold_q : imem.imem_rdata;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // Next state, PC/hold updates and IF/ID outputs.
    always_comb begin
        state_d     = state_q;
        pc_we       = 1'b0;
        pc_d        = pc_q;
        hold_we     = 1'b0;
        req         = 1'b0;
        out_instr   = '0;
        out_PC_inc  = '0;
        out_stall_n = 1'b0;
        halted      = (state_q == ST_HALT);

        if (redirect) begin
            // Request is suppressed on a redirect so no stale fetch can be accepted.
            pc_we       = 1'b1;
            pc_d        = redirect_pc;
            out_instr   = NOP_INSTR;
            out_PC_inc  = redirect_pc;
            out_stall_n = 1'b1;
            // A response landing this cycle retires the outstanding request, so DRAIN is only
            // entered (or kept) while one is still in flight.
            if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !imem.imem_done) state_d = ST_DRAIN;
            else                                                              state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    req = !rst;
                    if (!imem.imem_busy) state_d = ST_WAIT;
                end
                ST_WAIT, ST_HOLD: begin
                    if (cand_valid) begin
                        out_instr  = cand_instr;
                        out_PC_inc = pc_inc;
                        if (stall_n) begin
                            out_stall_n = 1'b1;
                            if (is_halt(cand_instr, HALT_OPCODE)) begin
                                state_d = ST_HALT;
                            end else begin
                                pc_we   = 1'b1;
                                pc_d    = pc_inc;
                                state_d = ST_FETCH;
                            end
                        end else if (state_q == ST_WAIT) begin
                            hold_we = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (imem.imem_done) state_d = ST_FETCH;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_ERR_EN
    logic err_q, err_d;

    // Flag unknown inputs or a response with no request outstanding.
    always_comb begin
        err_d = err_q;
        if ((^{stall_n, redirect, redirect_pc, imem.imem_busy, imem.imem_done, imem.imem_rdata}) === 1'bx)
            err_d = 1'b1;
        if (imem.imem_done && (state_q == ST_FETCH || state_q == ST_HOLD || state_q == ST_HALT))
            err_d = 1'b1;
    end

    // Sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic checked against a program-order reference model.
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOP    = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_n, redirect;
    logic [15:0] redirect_pc;
    logic [15:0] out_instr, out_PC_inc;
    logic        out_stall_n, halted, err;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(RST_PC), .HALT_OPCODE(5'b00000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall_n(stall_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem(imem), .out_instr(out_instr), .out_PC_inc(out_PC_inc),
        .out_stall_n(out_stall_n), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Memory model: contents by address, single outstanding request.
    logic [15:0] ovr [logic [15:0]];
    int unsigned lat = 1, busy_pct = 0, cnt = 0;
    logic        pend = 1'b0;
    logic [15:0] paddr;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [14:0] lo;
        if (ovr.exists(a)) return ovr[a];
        lo = (a[14:0] ^ 15'h2A5B) + 15'd7;
        return {1'b1, lo};
    endfunction

    task automatic tick();
        logic acc, dprev;
        logic [15:0] aaddr;
        acc   = imem.imem_req & ~imem.imem_busy;
        aaddr = imem.imem_addr;
        dprev = imem.imem_done;
        @(posedge clk);
        #1;
        if (dprev) pend = 1'b0;
        if (acc) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = aaddr;
        end
        imem.imem_done  = 1'b0;
        imem.imem_rdata = 16'($urandom);
        if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                imem.imem_done  = 1'b1;
                imem.imem_rdata = mem_word(paddr);
            end
        end
        imem.imem_busy = ($urandom_range(99) < busy_pct);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall_n = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem.imem_busy = 1'b0; imem.imem_done = 1'b0; imem.imem_rdata = '0;
        pend = 1'b0; cnt = 0; busy_pct = 0; lat = 1;
        ovr.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic found;
        rst = 1'b1; stall_n = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem.imem_busy = 1'b0; imem.imem_done = 1'b0; imem.imem_rdata = '0;
        @(posedge clk); #1;
        checks++; if (imem.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", imem.imem_req); end
        checks++; if (imem.imem_addr !== RST_PC) begin failures++; $display("FAIL rst_addr: got %h expected %h", imem.imem_addr, RST_PC); end
        checks++; if (out_stall_n !== 1'b0) begin failures++; $display("FAIL rst_stall_n: got %b expected 0", out_stall_n); end
        checks++; if (out_instr !== 16'h0000) begin failures++; $display("FAIL rst_instr: got %h expected 0000", out_instr); end
        checks++; if (out_PC_inc !== 16'h0000) begin failures++; $display("FAIL rst_pcinc: got %h expected 0000", out_PC_inc); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted: got %b expected 0", halted); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", err); end

        // Reset asserted mid-request, between clock edges.
        do_reset();
        lat = 2;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            #1;
        end
        checks++; if (imem.imem_addr !== 16'h0002) begin failures++; $display("FAIL pre_reset_addr: got %h expected 0002", imem.imem_addr); end
        rst = 1'b1;
        #1;
        checks++; if (imem.imem_addr !== RST_PC) begin failures++; $display("FAIL async_rst_addr: got %h expected %h", imem.imem_addr, RST_PC); end
        checks++; if (imem.imem_req !== 1'b0) begin failures++; $display("FAIL async_rst_req: got %b expected 0", imem.imem_req); end
        tick();
        rst = 1'b0;
        imem.imem_busy = 1'b1;
        #1;
        checks++; if (out_stall_n !== 1'b0) begin failures++; $display("FAIL stray_done_stall_n: got %b expected 0", out_stall_n); end
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== RST_PC) begin failures++; $display("FAIL stray_done_req: got req=%b addr=%h expected req=1 addr=%h", imem.imem_req, imem.imem_addr, RST_PC); end
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            #1;
            if (out_stall_n) begin
                found = 1'b1;
                checks++; if (out_instr !== mem_word(RST_PC)) begin failures++; $display("FAIL post_rst_instr: got %h expected %h", out_instr, mem_word(RST_PC)); end
                checks++; if (out_PC_inc !== RST_PC + 16'd2) begin failures++; $display("FAIL post_rst_pcinc: got %h expected %h", out_PC_inc, RST_PC + 16'd2); end
            end
        end
        checks++; if (!found) begin failures++; $display("FAIL post_rst_timeout: got no capture expected one"); end
    endtask

    task automatic test_sequential();
        int n = 0, first = -1, last = -1;
        do_reset();
        for (int c = 0; c < 12 && n < 3; c++) begin
            if (c > 0) tick();
            #1;
            if (out_stall_n) begin
                if (n == 0) first = c;
                checks++; if (out_PC_inc !== 16'(2 * (n + 1))) begin failures++; $display("FAIL seq_pcinc: got %h expected %h", out_PC_inc, 16'(2 * (n + 1))); end
                checks++; if (out_instr !== mem_word(16'(2 * n))) begin failures++; $display("FAIL seq_instr: got %h expected %h", out_instr, mem_word(16'(2 * n))); end
                if (n > 0) begin
                    checks++; if (c - last != 2) begin failures++; $display("FAIL seq_spacing: got %0d expected 2", c - last); end
                end
                last = c;
                n++;
            end
        end
        checks++; if (n != 3) begin failures++; $display("FAIL seq_count: got %0d expected 3", n); end
        checks++; if (first != 1) begin failures++; $display("FAIL seq_first_latency: got %0d expected 1", first); end
    endtask

    task automatic test_stall_hold();
        int seen = 0;
        do_reset();
        ovr[RST_PC] = 16'h4A21;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            stall_n = (c >= 5);
            #1;
            if (c >= 1 && c <= 4) begin
                checks++; if (out_stall_n !== 1'b0) begin failures++; $display("FAIL hold_stall_n c%0d: got %b expected 0", c, out_stall_n); end
            end
            if (c >= 2 && c <= 4) begin
                checks++; if (imem.imem_req !== 1'b0) begin failures++; $display("FAIL hold_req c%0d: got %b expected 0", c, imem.imem_req); end
            end
            if (c == 5) begin
                checks++; if (out_stall_n !== 1'b1) begin failures++; $display("FAIL hold_release: got %b expected 1", out_stall_n); end
                checks++; if (out_instr !== 16'h4A21) begin failures++; $display("FAIL hold_instr: got %h expected 4a21", out_instr); end
                checks++; if (out_PC_inc !== 16'h0002) begin failures++; $display("FAIL hold_pcinc: got %h expected 0002", out_PC_inc); end
            end
            if (out_stall_n && out_instr == 16'h4A21) seen++;
        end
        checks++; if (seen != 1) begin failures++; $display("FAIL hold_once: got %0d expected 1", seen); end
    endtask

    task automatic test_redirect_drain();
        logic found = 1'b0;
        do_reset();
        lat = 3;
        for (int c = 0; c < 16 && !found; c++) begin
            if (c > 0) tick();
            redirect    = (c == 1);
            redirect_pc = 16'h0100;
            #1;
            if (c == 1) begin
                checks++; if (out_stall_n !== 1'b1) begin failures++; $display("FAIL rd_flush_we: got %b expected 1", out_stall_n); end
                checks++; if (out_instr !== NOP) begin failures++; $display("FAIL rd_flush_instr: got %h expected %h", out_instr, NOP); end
                checks++; if (out_PC_inc !== 16'h0100) begin failures++; $display("FAIL rd_flush_pcinc: got %h expected 0100", out_PC_inc); end
            end
            if (c == 2 || c == 3) begin
                checks++; if (out_stall_n !== 1'b0 || imem.imem_req !== 1'b0) begin failures++; $display("FAIL rd_drain c%0d: got we=%b req=%b expected 0 0", c, out_stall_n, imem.imem_req); end
            end
            if (c == 4) begin
                checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0100) begin failures++; $display("FAIL rd_next_req: got req=%b addr=%h expected 1 0100", imem.imem_req, imem.imem_addr); end
            end
            if (c > 4 && out_stall_n) begin
                found = 1'b1;
                checks++; if (out_instr !== mem_word(16'h0100) || out_PC_inc !== 16'h0102) begin failures++; $display("FAIL rd_resume: got %h/%h expected %h/0102", out_instr, out_PC_inc, mem_word(16'h0100)); end
            end
        end
        checks++; if (!found) begin failures++; $display("FAIL rd_resume_timeout: got no capture expected one"); end
    endtask

    task automatic test_halt();
        logic found = 1'b0;
        do_reset();
        ovr[RST_PC] = 16'h0000;
        for (int c = 0; c < 26 && !found; c++) begin
            if (c > 0) tick();
            redirect    = (c == 12);
            redirect_pc = 16'h0040;
            #1;
            if (c == 1) begin
                checks++; if (out_stall_n !== 1'b1 || out_instr !== 16'h0000 || out_PC_inc !== 16'h0002) begin failures++; $display("FAIL halt_present: got we=%b %h/%h expected 1 0000/0002", out_stall_n, out_instr, out_PC_inc); end
                checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_early: got %b expected 0", halted); end
            end
            if (c >= 2 && c <= 11) begin
                checks++; if (halted !== 1'b1 || imem.imem_req !== 1'b0 || out_stall_n !== 1'b0) begin failures++; $display("FAIL halt_idle c%0d: got halted=%b req=%b we=%b expected 1 0 0", c, halted, imem.imem_req, out_stall_n); end
            end
            if (c == 2) begin
                checks++; if (imem.imem_addr !== RST_PC) begin failures++; $display("FAIL halt_pc: got %h expected %h", imem.imem_addr, RST_PC); end
            end
            if (c == 12) begin
                checks++; if (out_stall_n !== 1'b1 || out_instr !== NOP || out_PC_inc !== 16'h0040) begin failures++; $display("FAIL halt_redirect: got we=%b %h/%h expected 1 %h/0040", out_stall_n, out_instr, out_PC_inc, NOP); end
            end
            if (c == 13) begin
                checks++; if (halted !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0040) begin failures++; $display("FAIL halt_resume: got halted=%b req=%b addr=%h expected 0 1 0040", halted, imem.imem_req, imem.imem_addr); end
            end
            if (c > 13 && out_stall_n) begin
                found = 1'b1;
                checks++; if (out_instr !== mem_word(16'h0040) || out_PC_inc !== 16'h0042) begin failures++; $display("FAIL halt_next: got %h/%h expected %h/0042", out_instr, out_PC_inc, mem_word(16'h0040)); end
            end
        end
        checks++; if (!found) begin failures++; $display("FAIL halt_next_timeout: got no capture expected one"); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            redirect    = (c == 0);
            redirect_pc = 16'hFFFE;
            #1;
            if (c == 0) begin
                checks++; if (out_stall_n !== 1'b1 || out_PC_inc !== 16'hFFFE) begin failures++; $display("FAIL wrap_redirect: got we=%b pcinc=%h expected 1 fffe", out_stall_n, out_PC_inc); end
            end
            if (c == 1) begin
                checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_req: got req=%b addr=%h expected 1 fffe", imem.imem_req, imem.imem_addr); end
            end
            if (c == 2) begin
                checks++; if (out_stall_n !== 1'b1 || out_PC_inc !== 16'h0000 || out_instr !== mem_word(16'hFFFE)) begin failures++; $display("FAIL wrap_pcinc: got we=%b %h/%h expected 1 %h/0000", out_stall_n, out_instr, out_PC_inc, mem_word(16'hFFFE)); end
            end
            if (c == 3) begin
                checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_next_addr: got req=%b addr=%h expected 1 0000", imem.imem_req, imem.imem_addr); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic found = 1'b0;
        do_reset();
        lat = 3;
        for (int c = 0; c < 16 && !found; c++) begin
            if (c > 0) tick();
            redirect    = (c == 1 || c == 2);
            redirect_pc = (c == 1) ? 16'h0200 : 16'h0300;
            #1;
            if (c == 2) begin
                checks++; if (out_stall_n !== 1'b1 || out_instr !== NOP || out_PC_inc !== 16'h0300) begin failures++; $display("FAIL b2b_second: got we=%b %h/%h expected 1 %h/0300", out_stall_n, out_instr, out_PC_inc, NOP); end
            end
            if (c == 3) begin
                checks++; if (out_stall_n !== 1'b0) begin failures++; $display("FAIL b2b_discard: got %b expected 0", out_stall_n); end
            end
            if (c == 4) begin
                checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0300) begin failures++; $display("FAIL b2b_req: got req=%b addr=%h expected 1 0300", imem.imem_req, imem.imem_addr); end
            end
            if (c > 4 && out_stall_n) begin
                found = 1'b1;
                checks++; if (out_instr !== mem_word(16'h0300) || out_PC_inc !== 16'h0302) begin failures++; $display("FAIL b2b_resume: got %h/%h expected %h/0302", out_instr, out_PC_inc, mem_word(16'h0300)); end
            end
        end
        checks++; if (!found) begin failures++; $display("FAIL b2b_timeout: got no capture expected one"); end
    endtask

    task automatic test_err();
        logic exp_err;
`ifdef FETCH_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        imem.imem_busy = 1'b1;
        imem.imem_done = 1'b1;
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_before_edge: got %b expected 0", err); end
        for (int c = 0; c < 4; c++) begin
            tick();
            imem.imem_busy = 1'b1;
            #1;
            checks++; if (err !== exp_err) begin failures++; $display("FAIL err_sticky c%0d: got %b expected %b", c, err, exp_err); end
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc, rpc;
        int caps = 0;
        do_reset();
        busy_pct = 30;
        exp_pc   = RST_PC;
        for (int c = 0; c < 800; c++) begin
            if (c > 0) tick();
            stall_n     = ($urandom_range(99) < 70);
            redirect    = ($urandom_range(99) < 4);
            rpc         = 16'($urandom);
            redirect_pc = {rpc[15:1], 1'b0};
            lat         = $urandom_range(1, 3);
            #1;
            if (redirect) begin
                checks++; if (out_stall_n !== 1'b1 || out_instr !== NOP || out_PC_inc !== redirect_pc) begin failures++; $display("FAIL rnd_redirect c%0d: got we=%b %h/%h expected 1 %h/%h", c, out_stall_n, out_instr, out_PC_inc, NOP, redirect_pc); end
                exp_pc = redirect_pc;
            end else begin
                if (out_stall_n) begin
                    checks++; if (stall_n !== 1'b1) begin failures++; $display("FAIL rnd_write_while_stalled c%0d: got we=1 expected 0", c); end
                    checks++; if (out_instr !== mem_word(exp_pc) || out_PC_inc !== exp_pc + 16'd2) begin failures++; $display("FAIL rnd_capture c%0d: got %h/%h expected %h/%h", c, out_instr, out_PC_inc, mem_word(exp_pc), exp_pc + 16'd2); end
                    exp_pc = exp_pc + 16'd2;
                    caps++;
                end
                if (imem.imem_req && !imem.imem_busy) begin
                    checks++; if (imem.imem_addr !== exp_pc) begin failures++; $display("FAIL rnd_req_addr c%0d: got %h expected %h", c, imem.imem_addr, exp_pc); end
                end
            end
        end
        checks++; if (caps < 20) begin failures++; $display("FAIL rnd_progress: got %0d captures expected >= 20", caps); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_drain();
        test_halt();
        test_wrap();
        test_back_to_back();
        test_err();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
